gray_binary_tracker: RTL

Registered Gray-to-binary decoder with step tracking: the receive end for Gray-coded counters, encoder wheels and async-FIFO pointers produced by the team's binary-to-Gray logic. Each valid Gray sample is converted to binary, compared with the previous sample, and classified as hold, up-step, down-step or illegal jump. A signed position counter and a saturating error counter sit downstream of the classifier.

---
 rtl/gray_binary_tracker.sv | 121 ++++++++++++
 1 files changed

// File: rtl/gray_binary_tracker.sv
// Registered Gray-to-binary decoder that classifies each accepted sample against
// the previous one (hold / up / down / illegal) and tracks net position and errors.
module gray_binary_tracker #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] g_in,
  input  logic             g_valid,
  input  logic             err_clr,
  output logic [WIDTH-1:0] b_out,
  output logic             b_valid,
  output logic             step_up,
  output logic             step_dn,
  output logic             step_err,
  output logic [CNT_W-1:0] position,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    ERR   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] prev, prev_nxt;
  logic [WIDTH-1:0] b_conv;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] b_out_nxt;
  logic             b_valid_nxt;
  logic             step_up_nxt;
  logic             step_dn_nxt;
  logic             step_err_nxt;
  logic [CNT_W-1:0] position_nxt;
  logic [CNT_W-1:0] err_count_nxt;
  logic             is_hold;
  logic             is_up;
  logic             is_dn;
  logic             is_ill;

  // Each binary bit is the parity of the Gray bits at and above it.
  for (genvar i = 0; i < WIDTH; i++) begin : g_conv
    assign b_conv[i] = ^g_in[WIDTH-1:i];
  end

  assign diff    = b_conv - prev;
  assign is_hold = (diff == '0);
  assign is_up   = (diff == WIDTH'(1));
  assign is_dn   = (diff == '1);
  assign is_ill  = !(is_hold || is_up || is_dn);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      prev      <= '0;
      b_out     <= '0;
      b_valid   <= 1'b0;
      step_up   <= 1'b0;
      step_dn   <= 1'b0;
      step_err  <= 1'b0;
      position  <= '0;
      err_count <= '0;
    end else begin
      state     <= state_nxt;
      prev      <= prev_nxt;
      b_out     <= b_out_nxt;
      b_valid   <= b_valid_nxt;
      step_up   <= step_up_nxt;
      step_dn   <= step_dn_nxt;
      step_err  <= step_err_nxt;
      position  <= position_nxt;
      err_count <= err_count_nxt;
    end
  end

  // A clear coinciding with a sample turns that sample into a fresh reference.
  always_comb begin
    state_nxt     = state;
    prev_nxt      = prev;
    b_out_nxt     = b_out;
    b_valid_nxt   = 1'b0;
    step_up_nxt   = 1'b0;
    step_dn_nxt   = 1'b0;
    step_err_nxt  = step_err;
    position_nxt  = position;
    err_count_nxt = err_count;

    if (g_valid) begin
      b_valid_nxt = 1'b1;
      b_out_nxt   = b_conv;
      prev_nxt    = b_conv;
      if (err_clr || state == IDLE) begin
        state_nxt    = TRACK;
        step_err_nxt = 1'b0;
      end else begin
        if (is_ill && err_count != '1) begin
          err_count_nxt = err_count + CNT_W'(1);
        end
        if (state == TRACK) begin
          if (is_up) begin
            step_up_nxt  = 1'b1;
            position_nxt = position + CNT_W'(1);
          end else if (is_dn) begin
            step_dn_nxt  = 1'b1;
            position_nxt = position - CNT_W'(1);
          end else if (is_ill) begin
            step_err_nxt = 1'b1;
            state_nxt    = ERR;
          end
        end
      end
    end else if (err_clr) begin
      state_nxt    = IDLE;
      step_err_nxt = 1'b0;
    end
  end

endmodule
